exp_result_reader: RTL and testbench

EXP_RESULT_READER -- requirements
Module: exp_result_reader

---
 rtl/exp_result_reader.sv | 89 ++++++++
 tb/tb_exp_result_reader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/exp_result_reader.sv
// exp_result_reader: FIFO of shifted exponential results, decoding each word into integer and fractional parts on read
module exp_result_reader #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrEn,
    input  logic [20:0]   wrData,
    input  logic [1:0]    ui,
    input  logic          rdEn,
    output logic          rdValid,
    output logic [20:0]   rdData,
    output logic [1:0]    intpart,
    output logic [15:0]   fracpart,
    output logic          fmtErr,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow
);
    logic [22:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_wr;
    logic          do_rd;
    logic [20:0]   pop_word;
    logic [1:0]    pop_ui;
    logic [20:0]   shifted;
    logic [20:0]   low_mask;
    logic [20:0]   high_mask;
    logic          pop_err;

    assign count = cnt;
    assign empty = cnt == '0;
    assign full  = cnt == (AW+1)'(DEPTH);
    assign do_wr = wrEn && !full;
    assign do_rd = rdEn && !empty;

    // decode the head entry so the popped word's fields are ready to register
    always_comb begin
        pop_word  = mem[rd_ptr][20:0];
        pop_ui    = mem[rd_ptr][22:21];
        shifted   = pop_word >> pop_ui;
        low_mask  = (21'd1 << pop_ui) - 21'd1;
        high_mask = ~((21'd1 << (5'd18 + 5'(pop_ui))) - 21'd1);
        pop_err   = |(pop_word & (low_mask | high_mask));
    end

    // storage has no reset; stale entries are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (!rst && do_wr) mem[wr_ptr] <= {ui, wrData};
    end

    // pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
            if (wrEn && full) overflow <= 1'b1;
        end
    end

    // registered read outputs, held between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rdValid  <= 1'b0;
            rdData   <= '0;
            intpart  <= '0;
            fracpart <= '0;
            fmtErr   <= 1'b0;
        end else begin
            rdValid <= do_rd;
            if (do_rd) begin
                rdData   <= pop_word;
                intpart  <= shifted[17:16];
                fracpart <= shifted[15:0];
                fmtErr   <= pop_err;
            end
        end
    end
endmodule

// File: tb/tb_exp_result_reader.sv
// tb_exp_result_reader: randomized and directed checks against a queue-based reference model
module tb_exp_result_reader;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wrEn = 1'b0;
    logic [20:0] wrData = '0;
    logic [1:0]  ui = '0;
    logic        rdEn = 1'b0;
    logic        rdValid;
    logic [20:0] rdData;
    logic [1:0]  intpart;
    logic [15:0] fracpart;
    logic        fmtErr;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        overflow;

    int total = 0;
    int bad = 0;

    logic [22:0] q[$];
    bit          m_valid, m_err, m_ovf;
    int unsigned m_data, m_int, m_frac;

    exp_result_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .wrEn(wrEn), .wrData(wrData), .ui(ui), .rdEn(rdEn),
        .rdValid(rdValid), .rdData(rdData), .intpart(intpart), .fracpart(fracpart),
        .fmtErr(fmtErr), .empty(empty), .full(full), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // one clock: drive inputs, advance the model, compare every output
    task automatic step(input bit w, input int unsigned d, input int unsigned u, input bit r, input bit rs);
        bit          was_full = q.size() == DEPTH;
        bit          was_empty = q.size() == 0;
        logic [22:0] e;
        int unsigned dv, uv, s;
        wrEn = w; wrData = d[20:0]; ui = u[1:0]; rdEn = r; rst = rs;
        @(posedge clk);
        #1;
        wrEn = 0; rdEn = 0; rst = 0;
        m_valid = 0;
        if (rs) begin
            q.delete();
            m_ovf = 0; m_data = 0; m_int = 0; m_frac = 0; m_err = 0;
        end else begin
            if (r && !was_empty) begin
                e = q.pop_front();
                dv = e[20:0];
                uv = e[22:21];
                s = dv / (1 << uv);
                m_valid = 1;
                m_data = dv;
                m_int = (s / 65536) % 4;
                m_frac = s % 65536;
                m_err = (dv % (1 << uv) != 0) || (dv >= (1 << (18 + uv)));
            end
            if (w && was_full) m_ovf = 1;
            else if (w) q.push_back({u[1:0], d[20:0]});
        end
        chk("rdValid", rdValid, m_valid);
        chk("rdData", rdData, m_data);
        chk("intpart", intpart, m_int);
        chk("fracpart", fracpart, m_frac);
        chk("fmtErr", fmtErr, m_err);
        chk("count", count, q.size());
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
    endtask

    initial begin
        step(0, 0, 0, 0, 1);
        // decoded value 1.5 with no format error
        step(1, 21'h060000, 2, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("dir_int", intpart, 2'b01);
        chk("dir_frac", fracpart, 16'h8000);
        chk("dir_err0", fmtErr, 0);
        // nonzero bit shifted out flags an error
        step(1, 21'h000001, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("dir_err1", fmtErr, 1);
        // fill past full, drain, read on empty
        for (int i = 1; i <= 9; i++) step(1, i, 0, 0, 0);
        chk("dir_ovf", overflow, 1);
        for (int i = 1; i <= 9; i++) step(0, 0, 0, 1, 0);
        chk("dir_empty", empty, 1);
        // simultaneous read and write while full
        step(0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) step(1, 16'h100 + i, 0, 0, 0);
        step(1, 21'h1abcd, 0, 1, 0);
        chk("dir_rw_full_data", rdData, 16'h101);
        chk("dir_rw_full_cnt", count, 7);
        // interleaved traffic wrapping the pointers
        for (int i = 0; i < 20; i++) begin
            step(1, 21'h2000 + i, i % 4, 0, 0);
            step(i % 3 == 0, 21'h3000 + i, 0, 1, 0);
        end
        while (!empty) step(0, 0, 0, 1, 0);
        // mid-stream reset with a write attempt
        for (int i = 0; i < 3; i++) step(1, 21'h777 + i, 1, 0, 0);
        step(1, 21'h555, 0, 0, 1);
        chk("dir_rst_empty", empty, 1);
        step(1, 21'h0abcd, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("dir_rst_data", rdData, 21'h0abcd);
        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 55, $urandom & 21'h1fffff, $urandom_range(0, 3),
                 $urandom_range(0, 99) < 45, $urandom_range(0, 99) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
